lcd_status_reader: RTL and testbench
====================================

// Module: lcd_status_reader
// PURPOSE
//  Read-side companion of the HD44780 LCD write driver: runs RW=1 bus cycles to fetch the busy flag (BF)
//  and address counter (AC), or a DDRAM/CGRAM data byte. In poll mode it repeats BF reads until the
//  panel is ready or a poll limit expires. It sits beside lcd_driver under digital_clock; the top
//  muxes lcd_rs/lcd_rw/lcd_e/lcd_data between the two blocks using bus_claim.
// PARAMETERS
//  T_AS      2     clk cycles RS/RW valid before E rises (address setup)
//  T_EH      12    clk cycles E held high; data sampled on last high cycle
//  T_AH      2     clk cycles RS/RW held after E falls
//  T_GAP     13    clk cycles E low before next poll read (E cycle >= T_AS+T_EH+T_AH+T_GAP)
//  MAX_POLLS 255   poll-mode read limit (1..255)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  req          in   1  start pulse; accepted only when busy=0
//  rs_sel       in   1  0 = BF/AC read (RS=0), 1 = data-RAM read (RS=1); sampled with req
//  poll         in   1  1 = repeat BF reads until BF=0 (ignored when rs_sel=1); sampled with req
//  lcd_data_in  in   8  LCD DB7..DB0 input path
//  busy         out  1  transaction in progress
//  done         out  1  one-cycle pulse at transaction end
//  timeout      out  1  valid with done: poll limit hit while BF still 1
//  rd_data      out  8  last byte sampled
//  bf           out  1  rd_data[7] of last BF/AC read
//  ac           out  7  rd_data[6:0] of last BF/AC read
//  poll_cnt     out  8  reads performed in last transaction
//  bus_claim    out  1  1 = this block owns LCD pins; top releases DB drivers
//  lcd_rs       out  1  register select
//  lcd_rw       out  1  read/write (1 during claim)
//  lcd_e        out  1  enable strobe
// BEHAVIOUR
//  Reset (synchronous, any state): state IDLE; busy, done, timeout, bus_claim, lcd_e, lcd_rs, lcd_rw = 0;
//   rd_data=8'h00, bf=0, ac=0, poll_cnt=0. lcd_e falls on the same edge even if mid-pulse.
//  FSM: IDLE -> SETUP (T_AS) -> E_HIGH (T_EH) -> HOLD (T_AH) -> [GAP (T_GAP) -> SETUP] | FIN -> IDLE.
//  IDLE: req=1 latches rs_sel/poll, poll_cnt<=0, busy<=1, bus_claim<=1, lcd_rw<=1, lcd_rs<=rs_sel.
//  SETUP: lcd_e=0, RS/RW stable. E_HIGH: lcd_e=1 all T_EH cycles; on last cycle
//   rd_data<=lcd_data_in, poll_cnt<=poll_cnt+1 (saturating at 255); if rs_sel=0: bf<=DB7, ac<=DB6:0.
//  HOLD exit: goto GAP if poll=1 && rs_sel=0 && sampled BF=1 && poll_cnt<MAX_POLLS; else FIN.
//  GAP: lcd_e=0, bus_claim stays 1, RS/RW held.
//  FIN (1 cycle): done=1, timeout=(poll && BF=1 && poll_cnt==MAX_POLLS), bus_claim<=0,
//   lcd_rw<=0, lcd_rs<=0, busy<=0 on next edge; IDLE accepts new req next cycle.
//  Latency, single read: req edge -> done = 1+T_AS+T_EH+T_AH cycles (defaults: 17).
//  Poll of N reads: N*(T_AS+T_EH+T_AH) + (N-1)*T_GAP + 1 cycles.
//  req while busy=1 ignored (no queueing). rs_sel/poll changes mid-transaction ignored.
//  timeout low except in FIN cycle; bf/ac/rd_data hold until next sample.
//  Phase counter width: clog2 of largest T_* ; all T_* >= 1.
// STRUCTURE
//  Shared include lcd_defs.vh: HD44780 timing defaults (T_AS/T_EH/T_AH/T_GAP), state encodings
//   (IDLE, SETUP, E_HIGH, HOLD, GAP, FIN), RS codes for instruction/data.
//  One sub-module: lcd_phase_timer (load value, decrement, last-cycle flag) reused per phase.
// TESTING
//  1 Single BF read, lcd_data_in=8'h85 -> lcd_e high exactly 12 cycles, done at cycle 17, bf=1, ac=7'h05, timeout=0.
//  2 Poll, BF=1 for 3 reads then 8'h12 -> poll_cnt=4, bf=0, ac=7'h12, timeout=0, 3 GAP phases, bus_claim=1 throughout.
//  3 Poll with MAX_POLLS=4, DB7 stuck 1 -> exactly 4 E pulses, done with timeout=1, poll_cnt=4.
//  4 rs_sel=1, poll=1, data 8'h41 -> one read, rd_data=8'h41, lcd_rs=1 during claim, bf/ac unchanged.
//  5 rst asserted during E_HIGH -> next edge lcd_e=0, bus_claim=0, busy=0, all outputs at reset values.
//  6 req pulsed while busy -> ignored, single done; back-to-back req at FIN+1 accepted, two transactions.

Source files
------------

// File: rtl/lcd_status_reader_pkg.sv
// Shared definitions for the HD44780 read-side controller.
//   - default bus timing in clk cycles (address setup, E high, address hold, inter-poll gap)
//   - poll limit default
//   - RS codes for instruction/status versus data-RAM access
//   - FSM state encoding
//   - a small helper that sizes the phase counter
package lcd_status_reader_pkg;

  localparam int LCD_T_AS      = 2;
  localparam int LCD_T_EH      = 12;
  localparam int LCD_T_AH      = 2;
  localparam int LCD_T_GAP     = 13;
  localparam int LCD_MAX_POLLS = 255;

  localparam logic LCD_RS_INSTR = 1'b0;
  localparam logic LCD_RS_DATA  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_E_HIGH = 3'd2,
    ST_HOLD   = 3'd3,
    ST_GAP    = 3'd4,
    ST_FIN    = 3'd5
  } state_e;

  // Counter width that can hold (largest phase length - 1), never below 1 bit.
  function automatic int phase_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/lcd_status_reader_phase_timer.sv
// Phase down-counter shared by every bus phase.
//   clk, rst    : clock, synchronous active-high reset
//   load_i      : load load_val_i (phase length - 1) this edge
//   load_val_i  : value to load
//   last_o      : 1 while the current cycle is the last cycle of the phase
module lcd_status_reader_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)           cnt_d = load_val_i;
    else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780 read-side controller: runs RW=1 bus cycles to fetch BF/AC or a data-RAM byte,
// optionally repeating BF reads until the panel reports ready or the poll limit is hit.
//   clk, rst            : clock, synchronous active-high reset
//   req, rs_sel, poll   : start pulse and its latched options
//   lcd_data_in         : DB7..DB0 from the panel
//   busy, done, timeout : transaction status (done/timeout are one-cycle pulses)
//   rd_data, bf, ac     : last sampled byte and its BF/AC split
//   poll_cnt            : reads performed in the last transaction
//   bus_claim           : this block owns the LCD pins
//   lcd_rs, lcd_rw, lcd_e : LCD control pins
//
// state  | meaning
// IDLE   | bus released, waiting for req
// SETUP  | RS/RW valid, E low (address setup)
// E_HIGH | E high, data sampled on last cycle
// HOLD   | E low, RS/RW held (address hold)
// GAP    | E low between poll reads, bus still claimed
// FIN    | done pulse, bus released on exit
module lcd_status_reader
  import lcd_status_reader_pkg::*;
#(
  parameter int T_AS      = LCD_T_AS,
  parameter int T_EH      = LCD_T_EH,
  parameter int T_AH      = LCD_T_AH,
  parameter int T_GAP     = LCD_T_GAP,
  parameter int MAX_POLLS = LCD_MAX_POLLS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rs_sel,
  input  logic       poll,
  input  logic [7:0] lcd_data_in,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rd_data,
  output logic       bf,
  output logic [6:0] ac,
  output logic [7:0] poll_cnt,
  output logic       bus_claim,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e
);

  localparam int         TW    = phase_width(T_AS, T_EH, T_AH, T_GAP);
  localparam logic [7:0] MAX_P = 8'(MAX_POLLS);

  state_e       state_q, state_d;
  logic         rs_q, rs_d;
  logic         poll_q, poll_d;
  logic [7:0]   rd_q, rd_d;
  logic         bf_q, bf_d;
  logic [6:0]   ac_q, ac_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         tmr_load;
  logic [TW-1:0] tmr_val;
  logic         tmr_last;

  lcd_status_reader_phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .last_o     (tmr_last)
  );

  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    poll_d   = poll_q;
    rd_d     = rd_q;
    bf_d     = bf_q;
    ac_d     = ac_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          rs_d     = rs_sel ? LCD_RS_DATA : LCD_RS_INSTR;
          // Polling only makes sense for status reads; drop it for data-RAM reads.
          poll_d   = poll & ~rs_sel;
          cnt_d    = '0;
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_AS - 1);
        end
      end
      ST_SETUP: begin
        if (tmr_last) begin
          state_d  = ST_E_HIGH;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_EH - 1);
        end
      end
      ST_E_HIGH: begin
        if (tmr_last) begin
          rd_d = lcd_data_in;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (rs_q == LCD_RS_INSTR) begin
            bf_d = lcd_data_in[7];
            ac_d = lcd_data_in[6:0];
          end
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_AH - 1);
        end
      end
      ST_HOLD: begin
        if (tmr_last) begin
          if (poll_q && bf_q && (cnt_q < MAX_P)) begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = TW'(T_GAP - 1);
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_GAP: begin
        if (tmr_last) begin
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_AS - 1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rs_q    <= 1'b0;
      poll_q  <= 1'b0;
      rd_q    <= 8'h00;
      bf_q    <= 1'b0;
      ac_q    <= 7'h00;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      poll_q  <= poll_d;
      rd_q    <= rd_d;
      bf_q    <= bf_d;
      ac_q    <= ac_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pin outputs decode straight from the state register so reset drops E on the same edge.
  assign busy      = (state_q != ST_IDLE);
  assign bus_claim = busy;
  assign lcd_rw    = bus_claim;
  assign lcd_rs    = rs_q & bus_claim;
  assign lcd_e     = (state_q == ST_E_HIGH);
  assign done      = (state_q == ST_FIN);
  assign timeout   = done & poll_q & bf_q & (cnt_q == MAX_P);
  assign rd_data   = rd_q;
  assign bf        = bf_q;
  assign ac        = ac_q;
  assign poll_cnt  = cnt_q;

endmodule

// File: tb/tb_lcd_status_reader.sv
module tb_lcd_status_reader;

  logic       clk = 1'b0;
  logic       rst, req, req4, rs_sel, poll;
  logic [7:0] lcd_data_in;

  logic       busy, done, timeout, bf, bus_claim, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] rd_data, poll_cnt;
  logic [6:0] ac;

  logic       busy4, done4, timeout4, bf4, bus_claim4, lcd_rs4, lcd_rw4, lcd_e4;
  logic [7:0] rd_data4, poll_cnt4;
  logic [6:0] ac4;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] data_seq [8];

  always #5 clk = ~clk;

  lcd_status_reader u_dut (
    .clk(clk), .rst(rst), .req(req), .rs_sel(rs_sel), .poll(poll), .lcd_data_in(lcd_data_in),
    .busy(busy), .done(done), .timeout(timeout), .rd_data(rd_data), .bf(bf), .ac(ac),
    .poll_cnt(poll_cnt), .bus_claim(bus_claim), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
  );

  lcd_status_reader #(.MAX_POLLS(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .rs_sel(rs_sel), .poll(poll), .lcd_data_in(lcd_data_in),
    .busy(busy4), .done(done4), .timeout(timeout4), .rd_data(rd_data4), .bf(bf4), .ac(ac4),
    .poll_cnt(poll_cnt4), .bus_claim(bus_claim4), .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .lcd_e(lcd_e4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction already requested on the chosen DUT until done or the cycle budget.
  // n counts edges with the req-sampling edge as 1; data_seq[k] is driven for the k-th E pulse.
  task automatic run_txn(input bit use4, input int max_cyc, input bit exp_rs,
                         output int n, output int pulses, output int e_hi, output int gaps,
                         output bit to_at_done, output bit claim_ok, output bit rs_ok,
                         output bit got_done);
    bit e, prev_e;
    int low_run;
    n = 0; pulses = 0; e_hi = 0; gaps = 0; low_run = 0;
    to_at_done = 0; claim_ok = 1; rs_ok = 1; got_done = 0; prev_e = 0;
    while (n < max_cyc && !got_done) begin
      step();
      n++;
      if (n == 1) begin req = 0; req4 = 0; end
      e = use4 ? lcd_e4 : lcd_e;
      if (e && !prev_e) begin
        if (pulses > 0 && low_run == 17) gaps++;
        lcd_data_in = data_seq[pulses & 7];
        pulses++;
      end
      if (e) begin
        e_hi++;
        low_run = 0;
      end else if (pulses > 0) low_run++;
      prev_e = e;
      if (use4) begin
        if (busy4 && !bus_claim4) claim_ok = 0;
        if (bus_claim4 && (lcd_rs4 != exp_rs || !lcd_rw4)) rs_ok = 0;
        if (done4) begin got_done = 1; to_at_done = timeout4; end
      end else begin
        if (busy && !bus_claim) claim_ok = 0;
        if (bus_claim && (lcd_rs != exp_rs || !lcd_rw)) rs_ok = 0;
        if (done) begin got_done = 1; to_at_done = timeout; end
      end
    end
  endtask

  initial begin
    int n, pulses, e_hi, gaps, dones, first_done, second_done;
    bit to_d, claim_ok, rs_ok, got_done;

    rst = 1; req = 0; req4 = 0; rs_sel = 0; poll = 0; lcd_data_in = 8'h00;
    for (int i = 0; i < 8; i++) data_seq[i] = 8'h00;
    step(); step();
    check("rst_busy",      busy,      1'b0);
    check("rst_claim",     bus_claim, 1'b0);
    check("rst_e",         lcd_e,     1'b0);
    check("rst_rw_rs",     {lcd_rw, lcd_rs}, 2'b00);
    check("rst_rd_data",   rd_data,   8'h00);
    check("rst_poll_cnt",  poll_cnt,  8'h00);
    rst = 0;
    step();

    // 1: single BF read
    data_seq[0] = 8'h85;
    req = 1; rs_sel = 0; poll = 0;
    run_txn(0, 60, 1'b0, n, pulses, e_hi, gaps, to_d, claim_ok, rs_ok, got_done);
    check("t1_done_seen", got_done, 1'b1);
    check("t1_latency",   n,        17);
    check("t1_e_cycles",  e_hi,     12);
    check("t1_pulses",    pulses,   1);
    check("t1_bf",        bf,       1'b1);
    check("t1_ac",        ac,       7'h05);
    check("t1_rd_data",   rd_data,  8'h85);
    check("t1_timeout",   to_d,     1'b0);
    check("t1_poll_cnt",  poll_cnt, 8'd1);
    check("t1_rs_rw",     rs_ok,    1'b1);
    step();
    check("t1_idle_busy", busy,     1'b0);

    // 2: poll, BF=1 for three reads then ready
    data_seq[0] = 8'hA3; data_seq[1] = 8'h8F; data_seq[2] = 8'hFF; data_seq[3] = 8'h12;
    req = 1; rs_sel = 0; poll = 1;
    run_txn(0, 200, 1'b0, n, pulses, e_hi, gaps, to_d, claim_ok, rs_ok, got_done);
    check("t2_done_seen", got_done, 1'b1);
    check("t2_latency",   n,        4*16 + 3*13 + 1);
    check("t2_pulses",    pulses,   4);
    check("t2_gaps",      gaps,     3);
    check("t2_poll_cnt",  poll_cnt, 8'd4);
    check("t2_bf",        bf,       1'b0);
    check("t2_ac",        ac,       7'h12);
    check("t2_timeout",   to_d,     1'b0);
    check("t2_claim",     claim_ok, 1'b1);
    step();

    // 3: poll limit 4, DB7 stuck high
    for (int i = 0; i < 8; i++) data_seq[i] = 8'hC0 | 8'(i);
    req4 = 1; rs_sel = 0; poll = 1;
    run_txn(1, 300, 1'b0, n, pulses, e_hi, gaps, to_d, claim_ok, rs_ok, got_done);
    check("t3_done_seen", got_done,  1'b1);
    check("t3_pulses",    pulses,    4);
    check("t3_latency",   n,         4*16 + 3*13 + 1);
    check("t3_timeout",   to_d,      1'b1);
    check("t3_poll_cnt",  poll_cnt4, 8'd4);
    check("t3_ac",        ac4,       7'h43);
    step();
    check("t3_timeout_low", timeout4, 1'b0);

    // 4: data-RAM read with poll requested (poll must be ignored)
    for (int i = 0; i < 8; i++) data_seq[i] = 8'hC1;
    data_seq[0] = 8'h41;
    req = 1; rs_sel = 1; poll = 1;
    run_txn(0, 200, 1'b1, n, pulses, e_hi, gaps, to_d, claim_ok, rs_ok, got_done);
    rs_sel = 0; poll = 0;
    check("t4_latency",   n,        17);
    check("t4_pulses",    pulses,   1);
    check("t4_rd_data",   rd_data,  8'h41);
    check("t4_rs_high",   rs_ok,    1'b1);
    check("t4_bf_hold",   bf,       1'b0);
    check("t4_ac_hold",   ac,       7'h12);
    check("t4_timeout",   to_d,     1'b0);
    step();

    // 5: reset during E_HIGH
    lcd_data_in = 8'hFF;
    req = 1;
    n = 0;
    step(); req = 0;
    while (!lcd_e && n < 20) begin step(); n++; end
    check("t5_reached_e", lcd_e, 1'b1);
    step(); step();
    check("t5_e_mid", lcd_e, 1'b1);
    rst = 1;
    step();
    check("t5_e",        lcd_e,     1'b0);
    check("t5_claim",    bus_claim, 1'b0);
    check("t5_busy",     busy,      1'b0);
    check("t5_rw_rs",    {lcd_rw, lcd_rs}, 2'b00);
    check("t5_done_to",  {done, timeout}, 2'b00);
    check("t5_rd_data",  rd_data,   8'h00);
    check("t5_bf_ac",    {bf, ac},  8'h00);
    check("t5_poll_cnt", poll_cnt,  8'h00);
    rst = 0;
    step();

    // 6: req while busy ignored; req held across FIN is taken in IDLE
    lcd_data_in = 8'h07;
    req = 1; rs_sel = 0; poll = 0;
    n = 0; dones = 0; first_done = 0; second_done = 0;
    while (n < 80 && dones < 2) begin
      step();
      n++;
      if (n == 1) req = 0;
      if (n == 5) req = 1;
      if (n == 6) req = 0;
      if (n == 19) req = 0;
      if (done) begin
        dones++;
        if (dones == 1) begin first_done = n; req = 1; end
        else second_done = n;
      end
    end
    check("t6_first_done",  first_done,  17);
    check("t6_second_done", second_done, 35);
    check("t6_done_count",  dones,       2);
    req = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done) dones++;
    end
    check("t6_no_extra", dones, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
